// File: rtl/pcm_gen_multi.sv
// Stereo I2S test-pattern generator: per-channel phase accumulators feed
// saw/triangle/square samples that are serialised MSB-first on adata.
module pcm_gen_multi #(
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 24,
  parameter int SLOT_W  = 32,
  parameter int BCK_DIV = 4
) (
  input  logic               scki,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] phase_inc_l,
  input  logic [PHASE_W-1:0] phase_inc_r,
  output logic               bck,
  output logic               lrck,
  output logic               adata,
  output logic               frame_strb
);

  localparam int DIV_W = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_V   = BIT_W'(SLOT_W);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PHASE_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [DATA_W-1:0]    sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic                 bck_q, bck_d, lrck_q, lrck_d, adata_q, adata_d;
  logic                 frame_strb_q, frame_strb_d;
  logic                 wrap_s, boundary_s;

  function automatic logic [DATA_W-1:0] wave(input logic [1:0] m, input logic [PHASE_W-1:0] acc);
    logic [DATA_W-1:0] t;
    logic [DATA_W-1:0] u;
    logic [DATA_W-1:0] w;
    t = acc[PHASE_W-1 -: DATA_W];
    u = acc[PHASE_W-2 -: DATA_W];
    case (m)
      2'd1:    w = t;
      2'd2:    w = (acc[PHASE_W-1] ? ~u : u) ^ {1'b1, {(DATA_W-1){1'b0}}};
      2'd3:    w = acc[PHASE_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      default: w = {DATA_W{1'b0}};
    endcase
    return w;
  endfunction

  // Slot position 0 is the trailing pad of the previous slot; data occupies 1..DATA_W.
  function automatic logic ser_bit(input logic [BIT_W-1:0] b, input logic [DATA_W-1:0] sl,
                                   input logic [DATA_W-1:0] sr);
    int                pos;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] sh;
    if (b >= SLOT_V) begin
      pos = int'(b) - SLOT_W;
      s   = sr;
    end else begin
      pos = int'(b);
      s   = sl;
    end
    if (pos >= 1 && pos <= DATA_W) begin
      sh = s << (pos - 1);
      return sh[DATA_W-1];
    end else begin
      return 1'b0;
    end
  endfunction

  // Next-state, counter, accumulator and output computation.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    acc_l_d      = acc_l_q;
    acc_r_d      = acc_r_q;
    sample_l_d   = sample_l_q;
    sample_r_d   = sample_r_q;
    frame_strb_d = 1'b0;
    wrap_s       = (div_cnt_q == DIV_LAST);
    boundary_s   = wrap_s && (bit_cnt_q == BIT_LAST);

    case (state_q)
      ST_IDLE: begin
        div_cnt_d = {DIV_W{1'b0}};
        bit_cnt_d = {BIT_W{1'b0}};
        if (enable) begin
          state_d    = ST_RUN;
          sample_l_d = {DATA_W{1'b0}};
          sample_r_d = {DATA_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (wrap_s) begin
          div_cnt_d = {DIV_W{1'b0}};
          bit_cnt_d = boundary_s ? {BIT_W{1'b0}} : bit_cnt_q + BIT_W'(1);
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
          bit_cnt_d = bit_cnt_q;
        end
        if (boundary_s) begin
          frame_strb_d = 1'b1;
          sample_l_d   = wave(mode, acc_l_q);
          sample_r_d   = wave(mode, acc_r_q);
          acc_l_d      = acc_l_q + phase_inc_l;
          acc_r_d      = acc_r_q + phase_inc_r;
          state_d      = enable ? ST_RUN : ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        div_cnt_d = {DIV_W{1'b0}};
        bit_cnt_d = {BIT_W{1'b0}};
      end
    endcase

    // Outputs are registered copies of what the next counter values imply;
    // zeroed counters in IDLE make bck/lrck/adata idle low.
    bck_d   = (div_cnt_d >= DIV_HALF);
    lrck_d  = (bit_cnt_d >= SLOT_V);
    adata_d = ser_bit(bit_cnt_d, sample_l_d, sample_r_d);
  end

  // State and datapath registers.
  always_ff @(posedge scki or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= {DIV_W{1'b0}};
      bit_cnt_q    <= {BIT_W{1'b0}};
      acc_l_q      <= {PHASE_W{1'b0}};
      acc_r_q      <= {PHASE_W{1'b0}};
      sample_l_q   <= {DATA_W{1'b0}};
      sample_r_q   <= {DATA_W{1'b0}};
      bck_q        <= 1'b0;
      lrck_q       <= 1'b0;
      adata_q      <= 1'b0;
      frame_strb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      acc_l_q      <= acc_l_d;
      acc_r_q      <= acc_r_d;
      sample_l_q   <= sample_l_d;
      sample_r_q   <= sample_r_d;
      bck_q        <= bck_d;
      lrck_q       <= lrck_d;
      adata_q      <= adata_d;
      frame_strb_q <= frame_strb_d;
    end
  end

  assign bck        = bck_q;
  assign lrck       = lrck_q;
  assign adata      = adata_q;
  assign frame_strb = frame_strb_q;

endmodule

// File: tb/tb_pcm_gen_multi.sv
// Self-checking bench for pcm_gen_multi: an I2S receiver model decodes each
// frame and compares it with expected samples queued when each run is started.
module tb_pcm_gen_multi;

  logic        scki = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] phase_inc_l = 24'h0;
  logic [23:0] phase_inc_r = 24'h0;
  logic        bck, lrck, adata, frame_strb;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [23:0] acc_l_m = 24'h0;
  logic [23:0] acc_r_m = 24'h0;

  logic bits[64];
  logic lr[64];
  int   pos = 0;
  int   low_cnt = 0;
  int   frame_no = 0;
  logic prev_bck = 1'b0;

  pcm_gen_multi #(.DATA_W(16), .PHASE_W(24), .SLOT_W(32), .BCK_DIV(4)) dut (
    .scki(scki), .rst_n(rst_n), .enable(enable), .mode(mode),
    .phase_inc_l(phase_inc_l), .phase_inc_r(phase_inc_r),
    .bck(bck), .lrck(lrck), .adata(adata), .frame_strb(frame_strb)
  );

  always #5 scki = ~scki;

  function automatic logic [15:0] ref_wave(input logic [1:0] m, input logic [23:0] a);
    logic [15:0] u;
    case (m)
      2'd1: ref_wave = a[23:8];
      2'd2: begin
        u = a[22:7];
        if (a[23]) u = ~u;
        ref_wave = {~u[15], u[14:0]};
      end
      2'd3:    ref_wave = a[23] ? 16'h8000 : 16'h7FFF;
      default: ref_wave = 16'h0000;
    endcase
  endfunction

  // I2S receiver: captures adata/lrck on every bck rise and checks complete frames.
  always @(negedge scki) begin
    logic [15:0] lw, rw;
    logic [31:0] ev;
    bit          padbad, lrbad;
    if (!rst_n) begin
      pos = 0; low_cnt = 0; prev_bck = 1'b0;
    end else begin
      if (frame_strb) begin
        n_checks++;
        if (pos !== 64) $display("FAIL frame_len: %0d bck rises before frame_strb, required 64", pos);
        else n_pass++;
        pos = 0;
      end
      if (bck && !prev_bck) begin
        if (pos < 64) begin bits[pos] = adata; lr[pos] = lrck; end
        pos++;
        if (pos == 64) begin
          lw = 16'h0; rw = 16'h0; padbad = 1'b0; lrbad = 1'b0;
          for (int p = 0; p < 64; p++) begin
            if (p >= 1 && p <= 16) lw = {lw[14:0], bits[p]};
            else if (p >= 33 && p <= 48) rw = {rw[14:0], bits[p]};
            else if (bits[p] !== 1'b0) padbad = 1'b1;
            if (lr[p] !== (p >= 32)) lrbad = 1'b1;
          end
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL frame_unexpected: frame %0d L=%h R=%h, required no frame", frame_no, lw, rw);
          end else begin
            n_pass++;
            ev = exp_q.pop_front();
            n_checks++;
            if (lw !== ev[31:16]) $display("FAIL left_sample: frame %0d got %h, required %h", frame_no, lw, ev[31:16]);
            else n_pass++;
            n_checks++;
            if (rw !== ev[15:0]) $display("FAIL right_sample: frame %0d got %h, required %h", frame_no, rw, ev[15:0]);
            else n_pass++;
          end
          n_checks++;
          if (padbad) $display("FAIL padding: frame %0d has 1 in padding bits, required 0", frame_no);
          else n_pass++;
          n_checks++;
          if (lrbad) $display("FAIL lrck_pattern: frame %0d lrck wrong, required 0 for bck 0..31, 1 for 32..63", frame_no);
          else n_pass++;
          frame_no++;
        end
      end
      low_cnt = bck ? 0 : low_cnt + 1;
      if (low_cnt > 8) pos = 0;
      prev_bck = bck;
    end
  end

  task automatic wait_strobe(output int cyc);
    cyc = 0;
    do begin @(negedge scki); cyc++; end while (frame_strb !== 1'b1 && cyc < 600);
    n_checks++;
    if (frame_strb !== 1'b1) $display("FAIL strobe_timeout: no frame_strb in %0d cycles, required one", cyc);
    else n_pass++;
  endtask

  task automatic check_idle(input string tag);
    int bad = 0;
    repeat (20) begin
      @(negedge scki);
      if ({bck, lrck, adata, frame_strb} !== 4'b0000) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL idle_%s: %0d active cycles, required 0", tag, bad);
    else n_pass++;
  endtask

  task automatic apply_reset();
    @(negedge scki); rst_n = 1'b0; enable = 1'b0;
    exp_q.delete(); acc_l_m = 24'h0; acc_r_m = 24'h0;
    repeat (3) @(negedge scki);
    rst_n = 1'b1;
  endtask

  // Runs k frames: frame 0 carries zeros, frame f carries the waveform of the
  // model accumulators after f-1 increments; enable drops mid-way through the last frame.
  task automatic run_frames(input int k, input logic [1:0] m, input logic [23:0] il,
                            input logic [23:0] ir, input bit timing);
    logic [23:0] al, ar;
    logic [7:0]  pat;
    int          cyc, bad;
    mode = m; phase_inc_l = il; phase_inc_r = ir;
    al = acc_l_m; ar = acc_r_m;
    exp_q.push_back(32'h0);
    for (int f = 1; f < k; f++) begin
      exp_q.push_back({ref_wave(m, al), ref_wave(m, ar)});
      al = al + il; ar = ar + ir;
    end
    acc_l_m = al + il; acc_r_m = ar + ir;
    @(negedge scki); enable = 1'b1;
    if (timing) begin
      cyc = 0;
      do begin @(negedge scki); cyc++; end while (bck !== 1'b1 && cyc < 20);
      pat = 8'b10011001;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge scki);
        if (bck !== pat[i]) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL bck_waveform: %0d wrong samples, required period 4 high 2", bad);
      else n_pass++;
    end
    for (int s = 0; s < k; s++) begin
      if (s == k - 1) begin
        repeat (100) @(negedge scki);
        enable = 1'b0;
      end
      wait_strobe(cyc);
      if (timing && s == 1) begin
        n_checks++;
        if (cyc != 256) $display("FAIL frame_period: %0d scki, required 256", cyc);
        else n_pass++;
      end
    end
    repeat (4) @(negedge scki);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL frames_pending: %0d undelivered, required 0", exp_q.size());
    else n_pass++;
    check_idle("after_run");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge scki);
    n_checks++;
    if ({bck, lrck, adata, frame_strb} !== 4'b0000)
      $display("FAIL reset_outputs: got %b, required 0000", {bck, lrck, adata, frame_strb});
    else n_pass++;
    rst_n = 1'b1;
    check_idle("no_enable");
  endtask

  task automatic test_saw();
    run_frames(4, 2'd1, 24'h100000, 24'h200000, 1'b0);
  endtask

  task automatic test_timing();
    run_frames(3, 2'd1, 24'h010000, 24'h123456, 1'b1);
  endtask

  task automatic test_square();
    apply_reset();
    run_frames(6, 2'd3, 24'h400000, 24'h000000, 1'b0);
  endtask

  task automatic test_triangle();
    apply_reset();
    run_frames(5, 2'd2, 24'h400000, 24'h0C0000, 1'b0);
  endtask

  task automatic test_enable_drop();
    run_frames(3, 2'd1, 24'h080000, 24'h030000, 1'b0);
    run_frames(3, 2'd1, 24'h080000, 24'h030000, 1'b0);
  endtask

  task automatic test_async_reset();
    int cyc;
    mode = 2'd1; phase_inc_l = 24'h100000; phase_inc_r = 24'h080000;
    exp_q.push_back(32'h0);
    @(negedge scki); enable = 1'b1;
    wait_strobe(cyc);
    repeat (150) @(negedge scki);
    cyc = 0;
    while (bck !== 1'b1 && cyc < 8) begin @(negedge scki); cyc++; end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bck !== 1'b0) $display("FAIL async_rst_bck: got %b, required 0", bck);
    else n_pass++;
    n_checks++;
    if (lrck !== 1'b0) $display("FAIL async_rst_lrck: got %b, required 0", lrck);
    else n_pass++;
    n_checks++;
    if (adata !== 1'b0) $display("FAIL async_rst_adata: got %b, required 0", adata);
    else n_pass++;
    enable = 1'b0;
    exp_q.delete(); acc_l_m = 24'h0; acc_r_m = 24'h0;
    repeat (3) @(negedge scki);
    rst_n = 1'b1;
    run_frames(3, 2'd1, 24'h100000, 24'h080000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_saw();
    test_timing();
    test_square();
    test_triangle();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
